// File: rtl/ladybird_mem_arbiter_if.sv
// Bus bundle for the ladybird memory arbiter: I and D requester ports, shared M port and status.
// The slave modport is the arbiter's view; master is the surrounding core/memory environment.
interface ladybird_mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            i_req_valid;
   logic            i_req_ready;
   logic [XLEN-1:0] i_req_addr;
   logic            i_resp_valid;
   logic [XLEN-1:0] i_resp_data;

   logic            d_req_valid;
   logic            d_req_ready;
   logic [XLEN-1:0] d_req_addr;
   logic [XLEN-1:0] d_req_data;
   logic            d_req_we;
   logic [3:0]      d_req_strb;
   logic            d_resp_valid;
   logic [XLEN-1:0] d_resp_data;

   logic            m_req_valid;
   logic            m_req_ready;
   logic [XLEN-1:0] m_req_addr;
   logic [XLEN-1:0] m_req_data;
   logic            m_req_we;
   logic [3:0]      m_req_strb;
   logic            m_resp_valid;
   logic [XLEN-1:0] m_resp_data;

   logic            busy;
   logic            resp_error;

   modport slave (
      input  i_req_valid, i_req_addr,
      input  d_req_valid, d_req_addr, d_req_data, d_req_we, d_req_strb,
      input  m_req_ready, m_resp_valid, m_resp_data,
      output i_req_ready, i_resp_valid, i_resp_data,
      output d_req_ready, d_resp_valid, d_resp_data,
      output m_req_valid, m_req_addr, m_req_data, m_req_we, m_req_strb,
      output busy, resp_error
   );

   modport master (
      output i_req_valid, i_req_addr,
      output d_req_valid, d_req_addr, d_req_data, d_req_we, d_req_strb,
      output m_req_ready, m_resp_valid, m_resp_data,
      input  i_req_ready, i_resp_valid, i_resp_data,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  m_req_valid, m_req_addr, m_req_data, m_req_we, m_req_strb,
      input  busy, resp_error
   );
endinterface

// File: rtl/ladybird_mem_arbiter.sv
// Round-robin arbiter merging instruction-fetch (I) and load/store (D) onto one memory port.
// An in-order tag FIFO records which port owns each outstanding request to steer responses back.
module ladybird_mem_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   ladybird_mem_arbiter_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // LAST_x: unlocked, x was granted last. LOCK_x: x presented a request that stalled.
   typedef enum logic [1:0] {
      ST_LAST_I = 2'd0,
      ST_LAST_D = 2'd1,
      ST_LOCK_I = 2'd2,
      ST_LOCK_D = 2'd3
   } arb_state_t;

   arb_state_t      state;
   arb_state_t      state_nxt;

   logic            sel;
   logic            sel_vld;
   logic            full;
   logic            push;
   logic            pop;
   logic            head_tag;

   logic            tag_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            resp_error_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_LAST_I;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (push) begin
         state_nxt = (sel == PORT_D) ? ST_LAST_D : ST_LAST_I;
      end else if (bus.m_req_valid) begin
         state_nxt = (sel == PORT_D) ? ST_LOCK_D : ST_LOCK_I;
      end
   end

   always_comb begin
      sel     = PORT_I;
      sel_vld = 1'b0;
      unique case (state)
         ST_LOCK_I: begin
            sel     = PORT_I;
            sel_vld = bus.i_req_valid;
         end
         ST_LOCK_D: begin
            sel     = PORT_D;
            sel_vld = bus.d_req_valid;
         end
         default: begin
            if (bus.i_req_valid && bus.d_req_valid) begin
               sel     = (state == ST_LAST_I) ? PORT_D : PORT_I;
               sel_vld = 1'b1;
            end else if (bus.d_req_valid) begin
               sel     = PORT_D;
               sel_vld = 1'b1;
            end else if (bus.i_req_valid) begin
               sel     = PORT_I;
               sel_vld = 1'b1;
            end
         end
      endcase

      bus.m_req_valid = sel_vld & ~full;
      bus.i_req_ready = bus.m_req_valid & bus.m_req_ready & (sel == PORT_I);
      bus.d_req_ready = bus.m_req_valid & bus.m_req_ready & (sel == PORT_D);

      // Payload is forced to zero when nothing is selected so idle outputs read as 0.
      bus.m_req_addr = '0;
      bus.m_req_data = '0;
      bus.m_req_we   = 1'b0;
      bus.m_req_strb = 4'h0;
      if (sel_vld) begin
         if (sel == PORT_D) begin
            bus.m_req_addr = bus.d_req_addr;
            bus.m_req_data = bus.d_req_data;
            bus.m_req_we   = bus.d_req_we;
            bus.m_req_strb = bus.d_req_strb;
         end else begin
            bus.m_req_addr = bus.i_req_addr;
            bus.m_req_strb = 4'hF;
         end
      end
   end

   assign full     = (count == CW'(DEPTH));
   assign push     = bus.m_req_valid & bus.m_req_ready;
   assign pop      = bus.m_resp_valid & (count != '0);
   assign head_tag = tag_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= sel;
      end
   end

   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         resp_error_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (bus.m_resp_valid && (count == '0)) begin
            resp_error_q <= 1'b1;
         end
      end
   end

   assign bus.i_resp_valid = pop & (head_tag == PORT_I);
   assign bus.d_resp_valid = pop & (head_tag == PORT_D);
   assign bus.i_resp_data  = bus.m_resp_data;
   assign bus.d_resp_data  = bus.m_resp_data;
   assign bus.busy         = (count != '0);
   assign bus.resp_error   = resp_error_q;
endmodule

// File: tb/tb_ladybird_mem_arbiter.sv
// Bench for ladybird_mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based model of the arbitration and steering rules.
module tb_ladybird_mem_arbiter;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ladybird_mem_arbiter_if #(.XLEN(XLEN)) bus ();

   ladybird_mem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int pass_cnt = 0;
   int fail_cnt = 0;
   int chk_cnt  = 0;

   // Reference model state: last granted port, stall lock, queue of outstanding owners (0=I, 1=D).
   bit m_last, m_lock, m_owner, m_err;
   bit tagq[$];
   bit acc_i, acc_d;

   logic            e_sv, e_sel, e_mv, e_ir, e_dr, e_pop, e_irv, e_drv, e_busy, e_we;
   logic [XLEN-1:0] e_addr;
   logic [3:0]      e_strb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      assert (got === exp) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic predict();
      logic iv, dv, head;
      iv    = bus.i_req_valid;
      dv    = bus.d_req_valid;
      e_sel = 1'b0;
      e_sv  = 1'b0;
      if (m_lock) begin
         e_sel = m_owner;
         e_sv  = m_owner ? dv : iv;
      end else if (iv && dv) begin
         e_sel = !m_last;
         e_sv  = 1'b1;
      end else if (dv) begin
         e_sel = 1'b1;
         e_sv  = 1'b1;
      end else if (iv) begin
         e_sel = 1'b0;
         e_sv  = 1'b1;
      end
      e_mv   = e_sv && (tagq.size() < DEPTH);
      e_ir   = e_mv && bus.m_req_ready && !e_sel;
      e_dr   = e_mv && bus.m_req_ready && e_sel;
      e_addr = !e_sv ? '0 : (e_sel ? bus.d_req_addr : bus.i_req_addr);
      e_we   = e_sv && e_sel && bus.d_req_we;
      e_strb = !e_sv ? 4'h0 : (e_sel ? bus.d_req_strb : 4'hF);
      head   = (tagq.size() > 0) ? tagq[0] : 1'b0;
      e_pop  = bus.m_resp_valid && (tagq.size() > 0);
      e_irv  = e_pop && !head;
      e_drv  = e_pop && head;
      e_busy = (tagq.size() != 0);
   endtask

   task automatic compare_all();
      check("ctl", 32'({bus.m_req_valid, bus.i_req_ready, bus.d_req_ready, bus.i_resp_valid,
                        bus.d_resp_valid, bus.busy, bus.resp_error}),
                   32'({e_mv, e_ir, e_dr, e_irv, e_drv, e_busy, m_err}));
      check("m_req_addr", bus.m_req_addr, e_addr);
      check("m_req_we_strb", 32'({bus.m_req_we, bus.m_req_strb}), 32'({e_we, e_strb}));
      if (e_sv && e_sel) check("m_req_data", bus.m_req_data, bus.d_req_data);
      if (e_irv) check("i_resp_data", bus.i_resp_data, bus.m_resp_data);
      if (e_drv) check("d_resp_data", bus.d_resp_data, bus.m_resp_data);
   endtask

   task automatic update();
      acc_i = 1'b0;
      acc_d = 1'b0;
      if (rst) begin
         m_last  = 1'b0;
         m_lock  = 1'b0;
         m_owner = 1'b0;
         m_err   = 1'b0;
         tagq.delete();
      end else begin
         if (bus.m_resp_valid && tagq.size() == 0) m_err = 1'b1;
         if (e_pop) void'(tagq.pop_front());
         if (e_mv && bus.m_req_ready) begin
            tagq.push_back(e_sel);
            m_last = e_sel;
            m_lock = 1'b0;
            acc_i  = !e_sel;
            acc_d  = e_sel;
         end else if (e_mv) begin
            m_lock  = 1'b1;
            m_owner = e_sel;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      predict();
      compare_all();
   endtask

   task automatic advance();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic drain();
      bus.i_req_valid  = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.m_resp_valid = 1'b1;
      for (int n = 0; n < 2 * DEPTH && tagq.size() > 0; n++) begin
         bus.m_resp_data = $urandom;
         sample();
         advance();
      end
      bus.m_resp_valid = 1'b0;
      check("drain_busy", 32'(bus.busy), 32'(0));
   endtask

   bit i_pend, d_pend;

   initial begin
      rst              = 1'b1;
      bus.i_req_valid  = 1'b0;
      bus.i_req_addr   = '0;
      bus.d_req_valid  = 1'b0;
      bus.d_req_addr   = '0;
      bus.d_req_data   = '0;
      bus.d_req_we     = 1'b0;
      bus.d_req_strb   = 4'h0;
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
      advance();
      advance();
      rst = 1'b0;

      // Reset state
      sample();
      check("rst_outputs", 32'({bus.m_req_valid, bus.i_req_ready, bus.d_req_ready, bus.m_req_strb,
                                bus.busy, bus.resp_error}), 32'(0));
      advance();

      // Single I fetch, response two cycles later
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_0100;
      bus.m_req_ready = 1'b1;
      sample();
      check("ifetch_ready", 32'(bus.i_req_ready), 32'(1));
      check("ifetch_we_strb", 32'({bus.m_req_we, bus.m_req_strb}), 32'h0F);
      check("ifetch_addr", bus.m_req_addr, 32'h0000_0100);
      advance();
      bus.i_req_valid = 1'b0;
      sample();
      advance();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h0000_0013;
      sample();
      check("ifetch_resp", 32'({bus.i_resp_valid, bus.d_resp_valid}), 32'b10);
      check("ifetch_data", bus.i_resp_data, 32'h0000_0013);
      advance();
      bus.m_resp_valid = 1'b0;
      sample();
      check("ifetch_idle", 32'(bus.busy), 32'(0));
      advance();

      // Tie from reset history: D first, then alternate
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_1000;
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_2000;
      bus.d_req_data  = 32'hCAFE_0000;
      bus.d_req_we    = 1'b1;
      bus.d_req_strb  = 4'h3;
      for (int k = 0; k < 4; k++) begin
         sample();
         check("tie_grant", 32'({bus.d_req_ready, bus.i_req_ready}), (k % 2 == 0) ? 32'b10 : 32'b01);
         advance();
      end
      bus.i_req_valid  = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.m_resp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.m_resp_data = 32'h100 + 32'(k);
         sample();
         check("tie_steer", 32'({bus.d_resp_valid, bus.i_resp_valid}), (k % 2 == 0) ? 32'b10 : 32'b01);
         advance();
      end
      bus.m_resp_valid = 1'b0;

      // Stall lock: D held under backpressure while I waits
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_0200;
      bus.d_req_we    = 1'b0;
      bus.m_req_ready = 1'b1;
      sample();
      check("prime_d", 32'(bus.d_req_ready), 32'(1));
      advance();
      bus.d_req_addr  = 32'h0000_00A0;
      bus.m_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            bus.i_req_valid = 1'b1;
            bus.i_req_addr  = 32'h0000_0300;
         end
         sample();
         check("lock_addr", bus.m_req_addr, 32'h0000_00A0);
         advance();
      end
      bus.m_req_ready = 1'b1;
      sample();
      check("lock_accept_d", 32'({bus.d_req_ready, bus.i_req_ready}), 32'b10);
      advance();
      bus.d_req_valid = 1'b0;
      sample();
      check("lock_then_i", 32'(bus.i_req_ready), 32'(1));
      advance();
      drain();

      // Full FIFO blocks both ports; a same-cycle pop does not admit a push
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h0000_0400;
      bus.m_req_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         sample();
         check("fill_ready", 32'(bus.i_req_ready), 32'(1));
         advance();
      end
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_0500;
      sample();
      check("full_block", 32'({bus.m_req_valid, bus.i_req_ready, bus.d_req_ready}), 32'(0));
      advance();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h0000_0077;
      sample();
      check("full_pop_no_push", 32'({bus.m_req_valid, bus.i_resp_valid}), 32'b01);
      advance();
      bus.m_resp_valid = 1'b0;
      sample();
      check("full_resume", 32'(bus.m_req_valid), 32'(1));
      advance();
      bus.i_req_valid  = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.m_resp_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sample();
         advance();
      end

      // Simultaneous push/pop at two outstanding
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0000_0600;
      sample();
      check("pp_push", 32'(bus.d_req_ready), 32'(1));
      check("pp_steer", 32'({bus.i_resp_valid, bus.d_resp_valid}), 32'b10);
      advance();
      bus.d_req_valid  = 1'b0;
      bus.m_resp_valid = 1'b0;
      bus.i_req_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample();
         check("pp_room", 32'(bus.m_req_valid), (k < 2) ? 32'(1) : 32'(0));
         advance();
      end
      drain();

      // Spurious response is dropped and flagged until reset
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'hDEAD_BEEF;
      sample();
      check("spur_drop", 32'({bus.i_resp_valid, bus.d_resp_valid}), 32'(0));
      advance();
      bus.m_resp_valid = 1'b0;
      sample();
      check("spur_err", 32'(bus.resp_error), 32'(1));
      advance();
      sample();
      check("spur_held", 32'(bus.resp_error), 32'(1));
      rst = 1'b1;
      advance();
      rst = 1'b0;
      sample();
      check("spur_cleared", 32'({bus.resp_error, bus.busy}), 32'(0));
      advance();

      // Randomized traffic with occasional reset and spurious responses
      i_pend = 1'b0;
      d_pend = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (acc_i || rst) i_pend = 1'b0;
         if (acc_d || rst) d_pend = 1'b0;
         if (!i_pend && $urandom_range(0, 2) != 0) begin
            i_pend         = 1'b1;
            bus.i_req_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend         = 1'b1;
            bus.d_req_addr = $urandom;
            bus.d_req_data = $urandom;
            bus.d_req_we   = 1'($urandom_range(0, 1));
            bus.d_req_strb = 4'($urandom_range(0, 15));
         end
         rst              = ($urandom_range(0, 299) == 0);
         bus.i_req_valid  = i_pend;
         bus.d_req_valid  = d_pend;
         bus.m_req_ready  = ($urandom_range(0, 3) != 0);
         bus.m_resp_valid = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                              : ($urandom_range(0, 149) == 0);
         bus.m_resp_data  = $urandom;
         sample();
         advance();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
